i2s_adc_rx: RTL and testbench

- I2S receiver for the codec ADC path; the counterpart of the DAC serializer inside audio_codec.
- Takes the codec-driven bit clock, ADC LR clock and serial ADC data. Deserializes each frame into signed left/right samples in the sys_clk domain.
- Presents each stereo pair to downstream DSP/volume logic with a valid/ready handshake.
- Codec is master: this block never drives bclk or adclrc.

---
 rtl/i2s_adc_rx_if.sv | 33 +++
 rtl/i2s_adc_rx.sv | 180 ++++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_rx_if.sv
// i2s_adc_rx_if: sample-pair handshake between the I2S ADC receiver and its consumer.
//   data_left/data_right : signed stereo pair, MSB = first received bit
//   sample_valid         : pair available, held until accepted
//   sample_ready         : consumer accepts the pair when high with sample_valid
//   overrun              : sticky, a pair was overwritten before being accepted
// master = receiver side, slave = consumer side.
interface i2s_adc_rx_if #(
  parameter int unsigned DATA_WIDTH = 24
);

  logic signed [DATA_WIDTH-1:0] data_left;
  logic signed [DATA_WIDTH-1:0] data_right;
  logic                         sample_valid;
  logic                         sample_ready;
  logic                         overrun;

  modport master (
    output data_left,
    output data_right,
    output sample_valid,
    output overrun,
    input  sample_ready
  );

  modport slave (
    input  data_left,
    input  data_right,
    input  sample_valid,
    input  overrun,
    output sample_ready
  );

endinterface

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S receiver for the codec ADC path. The codec is bus master; bclk, adclrc and
// adcdat are oversampled in the sys_clk domain, deserialized MSB first and paired into signed
// left/right samples presented on a valid/ready handshake.
//   sys_clk : system clock (>= 8x bclk)
//   reset   : synchronous, active-low
//   bclk    : codec bit clock (asynchronous)
//   adclrc  : codec ADC LR clock
//   adcdat  : codec serial ADC data
//   smp     : pair output handshake (i2s_adc_rx_if.master)
// Build option: define I2S_ADC_RX_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit
// delay, adclrc high = left). Default is standard I2S (one-bit delay, adclrc low = left).
module i2s_adc_rx #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         bclk,
  input  logic         adclrc,
  input  logic         adcdat,
  i2s_adc_rx_if.master smp
);

  localparam int unsigned     CntW    = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StShift, StWait} state_e;

  // Synchronizers: not reset so the edge detectors track the live lines through reset and
  // no phantom adclrc edge appears on release.
  logic [SYNC_STAGES-1:0] bclk_sync_q, lrc_sync_q, dat_sync_q;
  logic                   bclk_prev_q, lrc_prev_q;
  logic                   bclk_s, lrc_s, dat_s, bclk_rise, lrc_edge, edge_left;

  always_ff @(posedge sys_clk) begin
    bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], adclrc};
    dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], adcdat};
    bclk_prev_q <= bclk_s;
    lrc_prev_q  <= lrc_s;
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrc_s     = lrc_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrc_edge  = lrc_s ^ lrc_prev_q;

`ifdef I2S_ADC_RX_LEFT_JUSTIFIED_EN
  localparam state_e StFirst = StShift;
  assign edge_left = lrc_s;
`else
  localparam state_e StFirst = StDelay;
  assign edge_left = ~lrc_s;
`endif

  state_e                state_q, state_d;
  logic                  left_q, left_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic                  left_pend_q, left_pend_d;
  logic [DATA_WIDTH-1:0] data_left_q, data_left_d;
  logic [DATA_WIDTH-1:0] data_right_q, data_right_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic                  word_done, store_left, pair_load, xfer;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    word      = shift_q;
    case (state_q)
      StIdle: begin
        if (lrc_edge) begin
          left_d  = edge_left;
          state_d = StFirst;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StDelay: begin
        if (lrc_edge) begin
          left_d = edge_left;
        end else if (bclk_rise) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        if (lrc_edge) begin
          // Short word: MSB-align the bits captured so far, zero-fill the LSBs.
          word_done = 1'b1;
          word      = shift_q << (DATA_WIDTH - 32'(cnt_q));
          left_d    = edge_left;
          state_d   = StFirst;
          cnt_d     = '0;
          shift_d   = '0;
        end else if (bclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], dat_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            word_done = 1'b1;
            word      = shift_d;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        if (lrc_edge) begin
          left_d  = edge_left;
          state_d = StFirst;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pairing and handshake. The completing right word bypasses its holding register so the
  // pair is visible one cycle after the last right bit is sampled.
  always_comb begin
    store_left   = word_done & left_q;
    pair_load    = word_done & ~left_q & left_pend_q;
    xfer         = valid_q & smp.sample_ready;
    hold_left_d  = store_left ? word : hold_left_q;
    left_pend_d  = store_left | (left_pend_q & ~pair_load);
    data_left_d  = data_left_q;
    data_right_d = data_right_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    if (pair_load) begin
      data_left_d  = hold_left_q;
      data_right_d = word;
      valid_d      = 1'b1;
      overrun_d    = overrun_q | (valid_q & ~smp.sample_ready);
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      left_q       <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_left_q  <= '0;
      left_pend_q  <= 1'b0;
      data_left_q  <= '0;
      data_right_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_left_q  <= hold_left_d;
      left_pend_q  <= left_pend_d;
      data_left_q  <= data_left_d;
      data_right_q <= data_right_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign smp.data_left    = data_left_q;
  assign smp.data_right   = data_right_q;
  assign smp.sample_valid = valid_q;
  assign smp.overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: drives I2S frames from the codec side, predicts each stereo pair from the raw
// slot bits and checks the handshake outputs cycle by cycle through a scoreboard queue.
module tb_i2s_adc_rx;

  localparam int unsigned W    = 24;
  localparam int unsigned SYNC = 2;
  localparam int          HALF = 8;  // sys_clk cycles per bclk half period: 3.125 MHz
`ifdef I2S_ADC_RX_LEFT_JUSTIFIED_EN
  localparam int          DLY      = 0;
  localparam bit          LEFT_LVL = 1'b1;
  localparam logic [W-1:0] RAW_EXP = 24'h123456;
`else
  localparam int          DLY      = 1;
  localparam bit          LEFT_LVL = 1'b0;
  localparam logic [W-1:0] RAW_EXP = 24'h2468AD;
`endif

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  logic bclk    = 1'b0;
  logic adclrc  = LEFT_LVL;
  logic adcdat  = 1'b0;
  logic ready   = 1'b0;

  i2s_adc_rx_if #(.DATA_WIDTH(W)) smp ();
  assign smp.sample_ready = ready;

  i2s_adc_rx #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bclk   (bclk),
    .adclrc (adclrc),
    .adcdat (adcdat),
    .smp    (smp)
  );

  always #10 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int unsigned  due;
  } pair_t;

  pair_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           left_pend = 1'b0;
  logic [W-1:0] left_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  // Word a receiver should extract from a slot: W bits after the framing delay, MSB first,
  // with bits beyond the end of the slot (short word) read as zero.
  function automatic logic [W-1:0] slot_word(input logic [63:0] sb, input int len);
    logic [63:0]  t;
    logic [W-1:0] w;
    t = sb << DLY;
    w = t[63 -: W];
    for (int i = 0; i < W; i++) if (i >= len - DLY) w[W-1-i] = 1'b0;
    return w;
  endfunction

  function automatic logic [63:0] place(input logic [W-1:0] w);
    logic [63:0] sb;
    sb = {$urandom, $urandom};
    sb[63-DLY -: W] = w;
    return sb;
  endfunction

  task automatic complete(input bit is_left, input logic [W-1:0] w, input int unsigned due);
    if (is_left) begin
      left_pend = 1'b1;
      left_word = w;
    end else if (left_pend) begin
      exp_q.push_back('{l: left_word, r: w, due: due});
      left_pend = 1'b0;
    end
  endtask

  // One slot: adclrc and data change with bclk falling. A short slot's word completes on the
  // adclrc edge that starts the next slot, i.e. right when this task returns.
  task automatic send_slot(input bit is_left, input logic [63:0] sb, input int len, input bit rec);
    logic [W-1:0] w;
    bit           full;
    w    = slot_word(sb, len);
    full = (len - DLY) >= int'(W);
    for (int i = 0; i < len; i++) begin
      bclk = 1'b0;
      if (i == 0) adclrc = is_left ? LEFT_LVL : ~LEFT_LVL;
      adcdat = sb[63-i];
      tick(HALF);
      bclk = 1'b1;
      if (rec && full && i == DLY + int'(W) - 1) complete(is_left, w, cyc + SYNC + 1);
      tick(HALF);
    end
    if (rec && !full) complete(is_left, w, cyc + SYNC + 1);
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r,
                       input int len_l, input int len_r);
    send_slot(1'b1, place(l), len_l, 1'b1);
    send_slot(1'b0, place(r), len_r, 1'b1);
  endtask

  task automatic reset_pulse(input int n);
    reset     = 1'b0;
    left_pend = 1'b0;
    tick(n);
    reset = 1'b1;
  endtask

  // Monitor: handshake-level model of the output register, advanced once per sys_clk.
  bit           m_valid = 1'b0, m_over = 1'b0;
  logic [W-1:0] m_l = '0, m_r = '0;
  logic         rst_prev = 1'b0, rdy_prev = 1'b0;
  int           xfers = 0;
  logic [W-1:0] last_l = '0, last_r = '0;

  always @(negedge sys_clk) begin
    pair_t p;
    bit    xfer;
    if (!rst_prev) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
      m_l     = '0;
      m_r     = '0;
    end else begin
      xfer = m_valid && rdy_prev;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        p = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL pair_missed: pair %0h/%0h due cycle %0d not loaded", p.l, p.r, p.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        p = exp_q.pop_front();
        if (m_valid && !xfer) m_over = 1'b1;
        m_valid = 1'b1;
        m_l     = p.l;
        m_r     = p.r;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
    chk("sample_valid", smp.sample_valid, m_valid);
    chk("overrun", smp.overrun, m_over);
    if (m_valid) begin
      chk("data_left", $unsigned(smp.data_left), m_l);
      chk("data_right", $unsigned(smp.data_right), m_r);
    end
    if (smp.sample_valid && ready) begin
      xfers++;
      last_l = smp.data_left;
      last_r = smp.data_right;
    end
    rst_prev = reset;
    rdy_prev = ready;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    bit rnd_done;
    rnd_done = 1'b0;
    tick(6);
    chk("rst_valid", smp.sample_valid, 1'b0);
    chk("rst_overrun", smp.overrun, 1'b0);
    chk("rst_data_left", $unsigned(smp.data_left), '0);
    reset = 1'b1;
    tick(4);

    // First right word after reset has no left partner and is dropped.
    ready = 1'b1;
    send_slot(1'b0, place(24'h55AA55), 32, 1'b1);
    frame(24'h7FFFFF, 24'h800001, 32, 32);
    chk("first_pair_count", xfers, 1);
    chk("max_left", last_l, 24'h7FFFFF);
    chk("min_right", last_r, 24'h800001);

    // Reset held 4 cycles mid-frame, then two unaccepted pairs.
    ready = 1'b0;
    fork
      send_slot(1'b1, place(24'h0F0F0F), 32, 1'b0);
      begin
        tick(200);
        reset_pulse(4);
        chk("mid_rst_valid", smp.sample_valid, 1'b0);
        chk("mid_rst_overrun", smp.overrun, 1'b0);
        chk("mid_rst_left", $unsigned(smp.data_left), '0);
        chk("mid_rst_right", $unsigned(smp.data_right), '0);
      end
    join
    send_slot(1'b0, place(24'h123123), 32, 1'b1);
    frame(24'h000010, 24'h000020, 32, 32);
    frame(24'h000030, 24'h000040, 32, 32);
    chk("ovr_flag", smp.overrun, 1'b1);
    chk("ovr_left", $unsigned(smp.data_left), 24'h000030);
    chk("ovr_right", $unsigned(smp.data_right), 24'h000040);
    ready = 1'b1;
    tick(3);
    chk("ovr_drained", smp.sample_valid, 1'b0);
    chk("ovr_sticky", smp.overrun, 1'b1);
    chk("ovr_xfer_left", last_l, 24'h000030);

    // Streaming with ready tied high.
    reset_pulse(4);
    x0 = xfers;
    for (int k = 0; k < 16; k++) frame(W'(2 * k + 1), W'(2 * k + 2), 32, 32);
    chk("stream_count", xfers - x0, 16);
    chk("stream_overrun", smp.overrun, 1'b0);
    chk("stream_last_left", last_l, W'(31));
    chk("stream_last_right", last_r, W'(32));

    // Short left word: 16 data bits then adclrc toggles.
    frame(24'hABCD00 | W'($urandom_range(1, 255)), 24'h13579B, DLY + 16, 32);
    chk("short_left", last_l, 24'hABCD00);
    chk("short_right", last_r, 24'h13579B);

    // MSB of 123456 on the first bclk rise after the left edge, followed by a 1.
    send_slot(1'b1, {24'h123456, 1'b1, 39'h0}, 32, 1'b1);
    send_slot(1'b0, place(24'h0F0F0F), 32, 1'b1);
    chk("framing_left", last_l, RAW_EXP);

    // Random words, random short slots and random backpressure.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          frame(W'($urandom), W'($urandom), $urandom_range(DLY + 4, 32),
                (k == 5) ? 32 : $urandom_range(DLY + 4, 32));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ready = 1'($urandom_range(0, 1));
          tick($urandom_range(1, 300));
        end
      end
    join
    ready = 1'b1;
    tick(50);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
